muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_iter_step.sv | 35 +++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states,
// and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    function automatic logic is_signed_rs1(input logic [2:0] funct3);
        return (funct3 == MULDIV_MUL)    || (funct3 == MULDIV_MULH) ||
               (funct3 == MULDIV_MULHSU) || (funct3 == MULDIV_DIV)  ||
               (funct3 == MULDIV_REM);
    endfunction

    function automatic logic is_signed_rs2(input logic [2:0] funct3);
        return (funct3 == MULDIV_MUL) || (funct3 == MULDIV_MULH) ||
               (funct3 == MULDIV_DIV) || (funct3 == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
// For divides the quotient-bit slot (o_acc[0]) is left clear; the caller ORs o_q_bit in.
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_operand,
    input  logic [2:0]        i_funct3,
    output logic [2*XLEN-1:0] o_acc,
    output logic              o_q_bit
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_shift;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum       = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_rem_shift = i_acc[2*XLEN-1:XLEN-1];
        w_diff      = w_rem_shift - {1'b0, i_operand};
        o_q_bit     = 1'b0;
        o_acc       = '0;
        if (is_div(i_funct3)) begin
            // No borrow means the shifted remainder covers the divisor: keep the difference.
            o_q_bit = ~w_diff[XLEN];
            o_acc   = {(o_q_bit ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0]),
                       i_acc[XLEN-2:0], 1'b0};
        end else begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; o_busy stalls the pipeline.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_t     r_state, w_next_state;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_operand;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_lo;
    logic              r_neg_rem;
    logic              r_special;
    logic [XLEN-1:0]   r_spec_res;

    logic              w_s1, w_s2;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_div0, w_ovf, w_special, w_fast_op, w_launch;
    logic [XLEN-1:0]   w_spec_res;
    logic [2*XLEN-1:0] w_step_acc, w_prod;
    logic              w_q_bit;
    logic [XLEN-1:0]   w_quot, w_rem, w_done_res, w_fast_res;

    assign w_s1      = is_signed_rs1(i_funct3) & i_rs1_data[XLEN-1];
    assign w_s2      = is_signed_rs2(i_funct3) & i_rs2_data[XLEN-1];
    assign w_a_mag   = w_s1 ? -i_rs1_data : i_rs1_data;
    assign w_b_mag   = w_s2 ? -i_rs2_data : i_rs2_data;
    assign w_div0    = is_div(i_funct3) & (i_rs2_data == '0);
    assign w_ovf     = is_div(i_funct3) & is_signed_rs1(i_funct3) &
                       (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2_data == '1);
    assign w_special = w_div0 | w_ovf;
    // Overflow quotient equals the dividend itself, so rs1 serves both special cases.
    assign w_spec_res = i_funct3[1] ? (w_div0 ? i_rs1_data : '0)
                                    : (w_div0 ? '1 : i_rs1_data);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa, w_fb;
    logic signed [2*XLEN+1:0] w_fast_prod;
    assign w_fa        = {is_signed_rs1(i_funct3) & i_rs1_data[XLEN-1], i_rs1_data};
    assign w_fb        = {is_signed_rs2(i_funct3) & i_rs2_data[XLEN-1], i_rs2_data};
    assign w_fast_prod = w_fa * w_fb;
    assign w_fast_res  = (i_funct3 == MULDIV_MUL) ? w_fast_prod[XLEN-1:0]
                                                  : w_fast_prod[2*XLEN-1:XLEN];
    assign w_fast_op   = ~is_div(i_funct3);
`else
    assign w_fast_res  = '0;
    assign w_fast_op   = 1'b0;
`endif

    assign w_launch = (r_state == ST_IDLE) & i_start & ~w_fast_op;

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_funct3  (r_funct3),
        .o_acc     (w_step_acc),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start && !w_fast_op) w_next_state = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == CW'(XLEN-1)) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_funct3   <= '0;
            r_operand  <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg_lo   <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
        end else if (w_launch) begin
            r_funct3   <= i_funct3;
            r_operand  <= w_b_mag;
            r_acc      <= {{XLEN{1'b0}}, w_a_mag};
            r_cnt      <= '0;
            r_neg_lo   <= w_s1 ^ w_s2;
            r_neg_rem  <= w_s1;
            r_special  <= w_special;
            r_spec_res <= w_spec_res;
        end else if (r_state == ST_CALC) begin
            r_acc <= w_step_acc | {{(2*XLEN-1){1'b0}}, w_q_bit};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_prod = r_neg_lo  ? -r_acc : r_acc;
    assign w_quot = r_neg_lo  ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_done_res = '0;
        if (r_special)                  w_done_res = r_spec_res;
        else if (r_funct3 == MULDIV_MUL) w_done_res = w_prod[XLEN-1:0];
        else if (!is_div(r_funct3))     w_done_res = w_prod[2*XLEN-1:XLEN];
        else if (!r_funct3[1])          w_done_res = w_quot;
        else                            w_done_res = w_rem;
    end

    always_comb begin
        o_busy   = 1'b0;
        o_valid  = 1'b0;
        o_result = '0;
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && w_fast_op) begin
                        o_valid  = 1'b1;
                        o_result = w_fast_res;
                    end else if (i_start) begin
                        o_busy = 1'b1;
                    end
                end
                ST_CALC: o_busy = 1'b1;
                ST_DONE: begin
                    o_valid  = 1'b1;
                    o_result = w_done_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with a result scoreboard.
// Honours MULDIV_FAST_MUL_EN for multiply latency expectations.
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [31:0]     sb[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat,
                          input bit hold);
        logic [31:0] exp;
        @(negedge clk);
        i_start    = 1'b1;
        i_funct3   = f3;
        i_rs1_data = a;
        i_rs2_data = b;
        sb.push_back(res);
        #1;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk({tag, "/busy"},  32'(o_busy),  32'(c < lat));
            chk({tag, "/valid"}, 32'(o_valid), 32'(c == lat));
            if (c == lat) begin
                exp = sb.pop_front();
                chk({tag, "/result"}, o_result, exp);
            end
        end
        if (!hold) i_start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        i_start    = 1'b0;
        i_funct3   = '0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst/busy",   32'(o_busy),  32'd0);
        chk("rst/valid",  32'(o_valid), 32'd0);
        chk("rst/result", o_result,     32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 1'b0);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 1'b0);
        run_op("mul_ovf",3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MUL_LAT, 1'b0);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, 1'b0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, 1'b0);
        run_op("divu",   3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, DIV_LAT, 1'b0);
        run_op("remu",   3'b111, 32'hFFFFFFF9, 32'd2,        32'd1,        DIV_LAT, 1'b0);
        run_op("div_nd", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, 1'b0);
        run_op("rem_nd", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT, 1'b0);
        run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT, 1'b0);
        run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        SPC_LAT, 1'b0);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT, 1'b0);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT, 1'b0);

        // Back-to-back: i_start stays high across DONE, MUL enters the very next cycle.
        run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);
        run_op("b2b_mul",  3'b000, 32'd6,   32'd7, 32'd42, MUL_LAT, 1'b0);

        // Reset asserted at cycle 10 of a DIV.
        @(negedge clk);
        i_start    = 1'b1;
        i_funct3   = 3'b100;
        i_rs1_data = 32'hFFFFFFF9;
        i_rs2_data = 32'd2;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk("rstmid/busy_pre", 32'(o_busy), 32'd1);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid/busy",   32'(o_busy),  32'd0);
        chk("rstmid/valid",  32'(o_valid), 32'd0);
        chk("rstmid/result", o_result,     32'd0);
        i_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
